// File: rtl/mcbsp0_tx_feeder_if.sv
// mcbsp0_tx_feeder_if
//   Bundles the producer-side write port, the frame control and status
//   lines, and the serializer handshake of the McBSP0 transmit feeder.
//   slave  : the feeder itself
//   master : the producer / serializer / control side (testbench)
//   Signals: wr_en, wr_data, fifo_full, fifo_level, frame_req, frame_words_m1,
//            mcbsp_master_en, mcbsp_data_out, mcbsp_update_in, busy,
//            frame_done, overflow_err, underrun_err, timeout_err, clr_err
interface mcbsp0_tx_feeder_if #(
  parameter int ADDR_W = 9
);
  logic              wr_en;
  logic [31:0]       wr_data;
  logic              fifo_full;
  logic [ADDR_W:0]   fifo_level;
  logic              frame_req;
  logic [8:0]        frame_words_m1;
  logic              mcbsp_master_en;
  logic [31:0]       mcbsp_data_out;
  logic              mcbsp_update_in;
  logic              busy;
  logic              frame_done;
  logic              overflow_err;
  logic              underrun_err;
  logic              timeout_err;
  logic              clr_err;

  modport slave (
    input  wr_en, wr_data, frame_req, frame_words_m1, mcbsp_update_in, clr_err,
    output fifo_full, fifo_level, mcbsp_master_en, mcbsp_data_out, busy,
           frame_done, overflow_err, underrun_err, timeout_err
  );

  modport master (
    output wr_en, wr_data, frame_req, frame_words_m1, mcbsp_update_in, clr_err,
    input  fifo_full, fifo_level, mcbsp_master_en, mcbsp_data_out, busy,
           frame_done, overflow_err, underrun_err, timeout_err
  );
endinterface

// File: rtl/mcbsp0_tx_feeder.sv
// mcbsp0_tx_feeder
//   Word source for the McBSP0 master serializer. Buffers producer words in a
//   first-word-fall-through FIFO; on frame_req waits until the whole frame is
//   buffered, strobes mcbsp_master_en for one clock with word 0 on the bus,
//   then pops one word per serializer update pulse. A guard gap follows every
//   frame. Overflow, underrun and timeout are reported as sticky flags.
//   Ports:
//     mcbsp_clk_in    : 20 MHz clock, all state on rising edge
//     mcbsp_rst_n_in  : asynchronous active-low reset
//     bus             : mcbsp0_tx_feeder_if.slave (FIFO, frame control, status)
module mcbsp0_tx_feeder #(
  parameter int ADDR_W      = 9,
  parameter int GUARD_CYC   = 40,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               mcbsp_clk_in,
  input  logic               mcbsp_rst_n_in,
  mcbsp0_tx_feeder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int GW    = $clog2(GUARD_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_STREAM, S_GUARD} state_t;

  state_t state, state_nx;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic [9:0]        n_words, wcnt;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;
  logic              aborted;
  logic              ovf_err, udr_err, to_err;

  logic empty, full, pop, push;
  logic upd, last, to_hit, g_end;

  assign empty = (level == '0);
  assign full  = (level == (ADDR_W+1)'(DEPTH));

  // A full FIFO still accepts a write when a pop frees the head slot in the
  // same cycle; the write lands in the slot being vacated.
  assign upd  = (state == S_STREAM) && bus.mcbsp_update_in;
  assign pop  = upd && !empty;
  assign push = bus.wr_en && (!full || pop);

  assign last   = upd && ((wcnt + 10'd1) == n_words);
  // An update in the same cycle as the timeout limit rescues the frame.
  assign to_hit = (state == S_STREAM) && !bus.mcbsp_update_in &&
                  (tcnt == TW'(TIMEOUT_CYC - 1));
  assign g_end  = (state == S_GUARD) && (gcnt == GW'(GUARD_CYC - 1));

  // ---------------- FSM: next state and strobes ----------------
  always_comb begin
    state_nx            = state;
    bus.mcbsp_master_en = 1'b0;
    bus.frame_done      = 1'b0;
    unique case (state)
      S_IDLE:   if (bus.frame_req) state_nx = S_FILL;
      S_FILL:   if (32'(level) >= 32'(n_words)) state_nx = S_START;
      S_START: begin
        bus.mcbsp_master_en = 1'b1;
        state_nx            = S_STREAM;
      end
      S_STREAM: if (last || to_hit) state_nx = S_GUARD;
      S_GUARD: begin
        if (g_end) begin
          state_nx       = S_IDLE;
          bus.frame_done = !aborted;
        end
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) state <= S_IDLE;
    else                 state <= state_nx;
  end

  // ---------------- frame counters ----------------
  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      n_words <= '0;
      wcnt    <= '0;
      tcnt    <= '0;
      gcnt    <= '0;
      aborted <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.frame_req) n_words <= 10'(bus.frame_words_m1) + 10'd1;
        S_START: begin
          wcnt    <= '0;
          tcnt    <= '0;
          aborted <= 1'b0;
        end
        S_STREAM: begin
          gcnt <= '0;
          if (upd) begin
            wcnt <= wcnt + 10'd1;
            tcnt <= '0;
          end else if (!to_hit) begin
            tcnt <= tcnt + TW'(1);
          end
          if (to_hit) aborted <= 1'b1;
        end
        S_GUARD: gcnt <= gcnt + GW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge mcbsp_clk_in) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // ---------------- sticky errors (set beats clear) ----------------
  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      ovf_err <= 1'b0;
      udr_err <= 1'b0;
      to_err  <= 1'b0;
    end else begin
      ovf_err <= (ovf_err && !bus.clr_err) || (bus.wr_en && full && !pop);
      udr_err <= (udr_err && !bus.clr_err) || (upd && empty);
      to_err  <= (to_err  && !bus.clr_err) || to_hit;
    end
  end

  assign bus.fifo_full      = full;
  assign bus.fifo_level     = level;
  assign bus.mcbsp_data_out = empty ? 32'd0 : mem[rd_ptr];
  assign bus.busy           = (state != S_IDLE);
  assign bus.overflow_err   = ovf_err;
  assign bus.underrun_err   = udr_err;
  assign bus.timeout_err    = to_err;

endmodule

// File: tb/tb_mcbsp0_tx_feeder.sv
// tb_mcbsp0_tx_feeder
//   Directed bench for mcbsp0_tx_feeder: frame sequencing, FILL wait,
//   overflow at full, simultaneous push/pop, timeout abort, and reset
//   mid-frame. Inputs change 1 time unit after the rising edge and outputs
//   are sampled at the same point.
module tb_mcbsp0_tx_feeder;
  localparam int ADDR_W      = 9;
  localparam int GUARD_CYC   = 40;
  localparam int TIMEOUT_CYC = 4096;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  mcbsp0_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  mcbsp0_tx_feeder #(
    .ADDR_W(ADDR_W), .GUARD_CYC(GUARD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .mcbsp_clk_in   (clk),
    .mcbsp_rst_n_in (rst_n),
    .bus            (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic upd();
    bus.mcbsp_update_in = 1'b1;
    tick();
    bus.mcbsp_update_in = 1'b0;
  endtask

  // frame_req pulse, then one FILL cycle -> now in START if data was buffered
  task automatic req(input logic [8:0] m1);
    bus.frame_words_m1 = m1;
    bus.frame_req      = 1'b1;
    tick();
    bus.frame_req      = 1'b0;
    tick();
  endtask

  // cycles until frame_done is seen (bounded); seen=0 on expiry
  task automatic wait_done(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = -1;
    for (int i = 0; i < GUARD_CYC + 20; i++) begin
      if (bus.frame_done) begin
        seen = 1'b1;
        cyc  = i;
        return;
      end
      tick();
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;

    rst_n               = 1'b0;
    bus.wr_en           = 1'b0;
    bus.wr_data         = '0;
    bus.frame_req       = 1'b0;
    bus.frame_words_m1  = '0;
    bus.mcbsp_update_in = 1'b0;
    bus.clr_err         = 1'b0;
    tick(); tick();
    chk("rst_level",   32'(bus.fifo_level), 0);
    chk("rst_data",    bus.mcbsp_data_out, 0);
    chk("rst_outs",    {bus.fifo_full, bus.mcbsp_master_en, bus.busy, bus.frame_done,
                        bus.overflow_err, bus.underrun_err, bus.timeout_err}, 0);
    #3 rst_n = 1'b1;
    tick();

    // ---- 1: basic 4-word frame ----
    for (int i = 1; i <= 4; i++) push(32'hA5A5_0000 + 32'(i));
    chk("t1_level4", 32'(bus.fifo_level), 4);
    bus.frame_words_m1 = 9'd3;
    bus.frame_req      = 1'b1;
    tick();
    bus.frame_req      = 1'b0;
    chk("t1_fill",   {bus.busy, bus.mcbsp_master_en}, 32'b10);
    tick();
    chk("t1_men",    bus.mcbsp_master_en, 1);
    chk("t1_word0",  bus.mcbsp_data_out, 32'hA5A5_0001);
    tick();
    chk("t1_men_off", bus.mcbsp_master_en, 0);
    upd(); chk("t1_word1", bus.mcbsp_data_out, 32'hA5A5_0002);
    upd(); chk("t1_word2", bus.mcbsp_data_out, 32'hA5A5_0003);
    upd(); chk("t1_word3", bus.mcbsp_data_out, 32'hA5A5_0004);
    upd(); chk("t1_empty", bus.mcbsp_data_out, 0);
    chk("t1_level0", 32'(bus.fifo_level), 0);
    wait_done(cyc, seen);
    chk("t1_done_seen", 32'(seen), 1);
    chk("t1_guard_len", 32'(cyc), GUARD_CYC - 1);
    tick();
    chk("t1_idle", bus.busy, 0);

    // ---- 2: FILL waits for the whole frame ----
    for (int i = 0; i < 3; i++) push(32'h20 + 32'(i));
    bus.frame_words_m1 = 9'd7;
    bus.frame_req      = 1'b1;
    tick();
    bus.frame_req      = 1'b0;
    tick(); tick();
    chk("t2_fill_wait", {bus.busy, bus.mcbsp_master_en}, 32'b10);
    for (int i = 3; i < 8; i++) push(32'h20 + 32'(i));
    chk("t2_level8", 32'(bus.fifo_level), 8);
    chk("t2_no_men_yet", bus.mcbsp_master_en, 0);
    tick();
    chk("t2_men",   bus.mcbsp_master_en, 1);
    chk("t2_word0", bus.mcbsp_data_out, 32'h20);
    tick();
    for (int i = 0; i < 8; i++) upd();
    chk("t2_level0", 32'(bus.fifo_level), 0);
    wait_done(cyc, seen);
    chk("t2_done_seen", 32'(seen), 1);
    tick();

    // ---- 3: overflow at full, then 512-word frame drains it ----
    for (int i = 0; i < 512; i++) push(32'h1000 + 32'(i));
    chk("t3_full",  bus.fifo_full, 1);
    chk("t3_level", 32'(bus.fifo_level), 512);
    push(32'hDEAD_BEEF);
    chk("t3_ovf",        bus.overflow_err, 1);
    chk("t3_level_keep", 32'(bus.fifo_level), 512);
    chk("t3_head_keep",  bus.mcbsp_data_out, 32'h1000);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("t3_clr", bus.overflow_err, 0);
    req(9'd511);
    chk("t3_men",   bus.mcbsp_master_en, 1);
    tick();
    for (int i = 0; i < 511; i++) upd();
    chk("t3_last_word", bus.mcbsp_data_out, 32'h1000 + 32'd511);
    upd();
    chk("t3_level0", 32'(bus.fifo_level), 0);
    chk("t3_data0",  bus.mcbsp_data_out, 0);
    wait_done(cyc, seen);
    chk("t3_done_seen", 32'(seen), 1);
    tick();

    // ---- 4: push and pop in the same cycle ----
    for (int i = 0; i < 6; i++) push(32'h40 + 32'(i));
    req(9'd5);
    chk("t4_men", bus.mcbsp_master_en, 1);
    tick();
    upd();
    chk("t4_level5", 32'(bus.fifo_level), 5);
    bus.wr_en = 1'b1; bus.wr_data = 32'h46; bus.mcbsp_update_in = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.mcbsp_update_in = 1'b0;
    chk("t4_level_same", 32'(bus.fifo_level), 5);
    chk("t4_head42",     bus.mcbsp_data_out, 32'h42);
    upd(); upd(); upd();
    chk("t4_head45", bus.mcbsp_data_out, 32'h45);
    upd();
    chk("t4_pushed_kept", bus.mcbsp_data_out, 32'h46);
    chk("t4_level1",      32'(bus.fifo_level), 1);
    wait_done(cyc, seen);
    chk("t4_done_seen", 32'(seen), 1);
    tick();

    // ---- 5: timeout abort ----
    for (int i = 0; i < 3; i++) push(32'h50 + 32'(i));
    req(9'd3);
    chk("t5_word0", bus.mcbsp_data_out, 32'h46);
    tick();
    upd();
    cyc = -1;
    for (int k = 1; k <= TIMEOUT_CYC + 100; k++) begin
      tick();
      if (bus.timeout_err) begin
        cyc = k;
        break;
      end
    end
    chk("t5_to_cycles", 32'(cyc), TIMEOUT_CYC);
    chk("t5_guard",     bus.busy, 1);
    seen = 1'b0;
    for (int i = 0; i < GUARD_CYC + 10; i++) begin
      if (bus.frame_done) seen = 1'b1;
      tick();
    end
    chk("t5_no_done",   32'(seen), 0);
    chk("t5_idle",      bus.busy, 0);
    chk("t5_left",      32'(bus.fifo_level), 3);
    chk("t5_head",      bus.mcbsp_data_out, 32'h50);
    chk("t5_no_udr",    bus.underrun_err, 0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("t5_clr", bus.timeout_err, 0);

    // ---- 6: reset mid-STREAM ----
    req(9'd1);
    chk("t6_men", bus.mcbsp_master_en, 1);
    tick();
    upd();
    chk("t6_streaming", {bus.busy, 27'd0, 4'(bus.fifo_level)}, {1'b1, 27'd0, 4'd2});
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level", 32'(bus.fifo_level), 0);
    chk("t6_rst_data",  bus.mcbsp_data_out, 0);
    chk("t6_rst_busy",  bus.busy, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("t6_idle", bus.busy, 0);
    push(32'h77);
    upd();
    chk("t6_idle_upd_ignored", 32'(bus.fifo_level), 1);
    chk("t6_head77",           bus.mcbsp_data_out, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
